// File: rtl/ivl_uvm_rr_onehot_arb.sv
// Round-robin arbiter with a registered zero-one-hot grant, released by done, request drop or hold timeout.
// Grant appears 1 cycle after the request is sampled; a mandatory idle cycle separates consecutive grants.
module ivl_uvm_rr_onehot_arb #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int HCW = $clog2(MAX_HOLD)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_id,
  output logic               timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic               timeout_q, timeout_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;

  logic               win_vld;
  logic [IDW-1:0]     win_idx;
  logic               owner_rel;
  logic               hold_exp;
  logic [IDW-1:0]     ptr_nxt;

  // Search ptr, ptr+1, ... modulo NUM_REQ; iterating backwards lets the entry closest to ptr win.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [IDW-1:0]     p);
    logic [IDW:0]   res;
    logic [IDW-1:0] kk;
    int unsigned    k;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k  = (int'(p) + i) % NUM_REQ;
      kk = IDW'(k);
      if (r[kk]) res = {1'b1, kk};
    end
    return res;
  endfunction

  always_comb begin
    {win_vld, win_idx} = rr_pick(req, ptr_q);
  end

  assign owner_rel = done[gnt_id_q] | ~req[gnt_id_q];
  assign hold_exp  = (hold_cnt_q == HCW'(MAX_HOLD - 1));
  assign ptr_nxt   = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && win_vld) begin
          state_d        = GRANT;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          gnt_id_d       = win_idx;
          hold_cnt_d     = '0;
        end
      end
      GRANT: begin
        // An owner release in the expiry cycle takes precedence, so no timeout pulse then.
        if (owner_rel || hold_exp) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = ptr_nxt;
          timeout_d = ~owner_rel;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

  a_gnt_onehot0 : assert property (@(posedge clock) disable iff (reset) $onehot0(gnt_q));
  a_gnt_valid   : assert property (@(posedge clock) disable iff (reset) gnt_valid_q == (|gnt_q));

endmodule
